// File: rtl/store_merge_unit_pkg.sv
// Shared definitions for the store merge path: store opcodes, FSM states,
// byte-lane masks and small alignment helpers.
package store_merge_unit_pkg;

    // Store operation encodings, numbered to parallel the load opcodes.
    typedef enum logic [2:0] {
        SOP_NONE = 3'b000,
        SOP_SB   = 3'b001,
        SOP_SH   = 3'b010,
        SOP_SW   = 3'b011
    } storeop_e;

    // Store FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Byte-lane masks (lane k = bits [8k+7:8k], little-endian).
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // True for the three opcodes that actually store something.
    function automatic logic is_store_op(input logic [2:0] op);
        logic ok;
        case (op)
            SOP_SB:  ok = 1'b1;
            SOP_SH:  ok = 1'b1;
            SOP_SW:  ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halfwords need an even address, words need a word-aligned address.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lane);
        logic bad;
        case (op)
            SOP_SH:  bad = lane[0];
            SOP_SW:  bad = (lane != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_merge_unit_if.sv
// Bundle of the pipeline-side store request signals and the word-wide
// memory port. The slave modport is the store unit; master is its environment.
interface store_merge_unit_if #(
    parameter int ADDR_W = 32
);
    logic              st_req;
    logic [2:0]        Storeop;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       datain;
    logic              st_busy;
    logic              st_done;
    logic              st_misalign;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport slave (
        input  st_req, Storeop, addr, datain, mem_rdata, mem_ack,
        output st_busy, st_done, st_misalign,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output st_req, Storeop, addr, datain, mem_rdata, mem_ack,
        input  st_busy, st_done, st_misalign,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/store_lane_merge.sv
// Combinational lane merge: inserts the byte/halfword/word store data into
// the old memory word and reports the lanes the store touches.
module store_lane_merge
    import store_merge_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] datain,
    input  logic [31:0] old_word,
    output logic [31:0] merged_word,
    output logic [3:0]  byte_en
);

    // Overwrite only the addressed lanes; everything else keeps old_word.
    always_comb begin
        merged_word = old_word;
        byte_en     = BE_NONE;
        case (op)
            SOP_SB: begin
                merged_word[{lane, 3'b000} +: 8] = datain[7:0];
                byte_en = BE_BYTE0 << lane;
            end
            SOP_SH: begin
                if (lane[1]) begin
                    merged_word[31:16] = datain[15:0];
                    byte_en = BE_HI_HALF;
                end else begin
                    merged_word[15:0] = datain[15:0];
                    byte_en = BE_LO_HALF;
                end
            end
            SOP_SW: begin
                merged_word = datain;
                byte_en     = BE_WORD;
            end
            default: begin
                merged_word = old_word;
                byte_en     = BE_NONE;
            end
        endcase
    end

endmodule

// File: rtl/store_merge_unit.sv
// Store merge unit: turns SB/SH/SW requests into full-word writes using
// read-modify-write for sub-word stores, and rejects misaligned stores.
module store_merge_unit
    import store_merge_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    store_merge_unit_if.slave sif
);

    state_e      state_r;
    logic [2:0]  op_r;
    logic [1:0]  lane_r;
    logic [31:0] data_r;

    logic [2:0]  sel_op_s;
    logic [1:0]  sel_lane_s;
    logic [31:0] sel_data_s;
    logic [31:0] merged_s;
    logic [3:0]  be_s;
    logic        accept_s;

    // In IDLE merge the live request (SW goes straight to write); afterwards
    // merge the captured request against the word coming back from memory.
    always_comb begin
        if (state_r == S_IDLE) begin
            sel_op_s   = sif.Storeop;
            sel_lane_s = sif.addr[1:0];
            sel_data_s = sif.datain;
        end else begin
            sel_op_s   = op_r;
            sel_lane_s = lane_r;
            sel_data_s = data_r;
        end
    end

    // A request is taken only when idle and carrying a real store opcode.
    always_comb begin
        if (state_r == S_IDLE) begin
            accept_s = sif.st_req & is_store_op(sif.Storeop);
        end else begin
            accept_s = 1'b0;
        end
    end

    store_lane_merge u_merge (
        .op          (sel_op_s),
        .lane        (sel_lane_s),
        .datain      (sel_data_s),
        .old_word    (sif.mem_rdata),
        .merged_word (merged_s),
        .byte_en     (be_s)
    );

    // Store FSM with all outputs registered; memory fields are loaded on
    // phase entry and held until the phase's ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= S_IDLE;
            op_r            <= 3'b000;
            lane_r          <= 2'b00;
            data_r          <= 32'h0000_0000;
            sif.st_busy     <= 1'b0;
            sif.st_done     <= 1'b0;
            sif.st_misalign <= 1'b0;
            sif.mem_req     <= 1'b0;
            sif.mem_we      <= 1'b0;
            sif.mem_addr    <= '0;
            sif.mem_wdata   <= 32'h0000_0000;
            sif.mem_be      <= BE_NONE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    sif.st_done     <= 1'b0;
                    sif.st_misalign <= 1'b0;
                    if (accept_s) begin
                        op_r        <= sif.Storeop;
                        lane_r      <= sif.addr[1:0];
                        data_r      <= sif.datain;
                        sif.st_busy <= 1'b1;
                        if (is_misaligned(sif.Storeop, sif.addr[1:0])) begin
                            state_r         <= S_DONE;
                            sif.st_done     <= 1'b1;
                            sif.st_misalign <= 1'b1;
                        end else if (sif.Storeop == SOP_SW) begin
                            state_r       <= S_WR;
                            sif.mem_req   <= 1'b1;
                            sif.mem_we    <= 1'b1;
                            sif.mem_addr  <= {sif.addr[ADDR_W-1:2], 2'b00};
                            sif.mem_wdata <= merged_s;
                            sif.mem_be    <= be_s;
                        end else begin
                            state_r      <= S_RD;
                            sif.mem_req  <= 1'b1;
                            sif.mem_we   <= 1'b0;
                            sif.mem_addr <= {sif.addr[ADDR_W-1:2], 2'b00};
                        end
                    end else begin
                        state_r     <= S_IDLE;
                        sif.st_busy <= 1'b0;
                    end
                end
                S_RD: begin
                    if (sif.mem_ack) begin
                        state_r       <= S_WR;
                        sif.mem_we    <= 1'b1;
                        sif.mem_wdata <= merged_s;
                        sif.mem_be    <= be_s;
                    end else begin
                        state_r <= S_RD;
                    end
                end
                S_WR: begin
                    if (sif.mem_ack) begin
                        state_r     <= S_DONE;
                        sif.mem_req <= 1'b0;
                        sif.mem_we  <= 1'b0;
                        sif.mem_be  <= BE_NONE;
                        sif.st_done <= 1'b1;
                    end else begin
                        state_r <= S_WR;
                    end
                end
                S_DONE: begin
                    state_r         <= S_IDLE;
                    sif.st_busy     <= 1'b0;
                    sif.st_done     <= 1'b0;
                    sif.st_misalign <= 1'b0;
                end
                default: begin
                    state_r         <= S_IDLE;
                    sif.st_busy     <= 1'b0;
                    sif.st_done     <= 1'b0;
                    sif.st_misalign <= 1'b0;
                    sif.mem_req     <= 1'b0;
                    sif.mem_we      <= 1'b0;
                    sif.mem_be      <= BE_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: SW, SB/SH read-modify-write, wait
// states, misalignment rejection, mid-transaction reset and ignored requests.
module tb_store_merge_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    store_merge_unit_if #(.ADDR_W(32)) bus ();

    store_merge_unit #(.ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        bus.st_req  = 1'b1;
        bus.Storeop = op;
        bus.addr    = a;
        bus.datain  = d;
    endtask

    task automatic idle_req();
        bus.st_req  = 1'b0;
        bus.Storeop = 3'b000;
        bus.addr    = 32'hFFFF_FFFF;
        bus.datain  = 32'h5A5A_5A5A;
    endtask

    // SW with immediate ack: write at +1, done at +2, idle at +3.
    task automatic run_sw(input string tag, input logic [31:0] a, input logic [31:0] d);
        bus.mem_ack = 1'b1;
        drive_req(3'b011, a, d);
        tick();
        idle_req();
        check({tag, "_req"},  {31'd0, bus.mem_req}, 32'd1);
        check({tag, "_we"},   {31'd0, bus.mem_we}, 32'd1);
        check({tag, "_addr"}, bus.mem_addr, {a[31:2], 2'b00});
        check({tag, "_wdat"}, bus.mem_wdata, d);
        check({tag, "_be"},   {28'd0, bus.mem_be}, 32'h0000_000F);
        check({tag, "_nodone"}, {31'd0, bus.st_done}, 32'd0);
        tick();
        check({tag, "_done"}, {31'd0, bus.st_done}, 32'd1);
        check({tag, "_mis"},  {31'd0, bus.st_misalign}, 32'd0);
        check({tag, "_busyd"}, {31'd0, bus.st_busy}, 32'd1);
        check({tag, "_reqoff"}, {31'd0, bus.mem_req}, 32'd0);
        tick();
        check({tag, "_idle"}, {31'd0, bus.st_busy}, 32'd0);
        check({tag, "_done0"}, {31'd0, bus.st_done}, 32'd0);
        bus.mem_ack = 1'b0;
    endtask

    // SB/SH with immediate ack: read at +1, write at +2, done at +3.
    task automatic run_rmw(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] mem_word,
                           input logic [31:0] exp_w, input logic [3:0] exp_be);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_word;
        drive_req(op, a, d);
        tick();
        idle_req();
        check({tag, "_rreq"},  {31'd0, bus.mem_req}, 32'd1);
        check({tag, "_rwe"},   {31'd0, bus.mem_we}, 32'd0);
        check({tag, "_raddr"}, bus.mem_addr, {a[31:2], 2'b00});
        tick();
        bus.mem_rdata = 32'hFFFF_FFFF;
        check({tag, "_wreq"},  {31'd0, bus.mem_req}, 32'd1);
        check({tag, "_wwe"},   {31'd0, bus.mem_we}, 32'd1);
        check({tag, "_waddr"}, bus.mem_addr, {a[31:2], 2'b00});
        check({tag, "_wdat"},  bus.mem_wdata, exp_w);
        check({tag, "_be"},    {28'd0, bus.mem_be}, {28'd0, exp_be});
        tick();
        check({tag, "_done"},  {31'd0, bus.st_done}, 32'd1);
        check({tag, "_mis"},   {31'd0, bus.st_misalign}, 32'd0);
        tick();
        check({tag, "_idle"},  {31'd0, bus.st_busy}, 32'd0);
        bus.mem_ack = 1'b0;
    endtask

    // Misaligned store: done+misalign at +1 with no memory request.
    task automatic run_mis(input string tag, input logic [2:0] op, input logic [31:0] a);
        bus.mem_ack = 1'b0;
        drive_req(op, a, 32'h1234_5678);
        tick();
        idle_req();
        check({tag, "_done"}, {31'd0, bus.st_done}, 32'd1);
        check({tag, "_mis"},  {31'd0, bus.st_misalign}, 32'd1);
        check({tag, "_req"},  {31'd0, bus.mem_req}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.st_busy}, 32'd1);
        tick();
        check({tag, "_done0"}, {31'd0, bus.st_done}, 32'd0);
        check({tag, "_mis0"},  {31'd0, bus.st_misalign}, 32'd0);
        check({tag, "_idle"},  {31'd0, bus.st_busy}, 32'd0);
        check({tag, "_req0"},  {31'd0, bus.mem_req}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0000_0000;
        idle_req();

        // Reset state
        tick();
        tick();
        check("rst_busy",  {31'd0, bus.st_busy}, 32'd0);
        check("rst_done",  {31'd0, bus.st_done}, 32'd0);
        check("rst_mis",   {31'd0, bus.st_misalign}, 32'd0);
        check("rst_req",   {31'd0, bus.mem_req}, 32'd0);
        check("rst_we",    {31'd0, bus.mem_we}, 32'd0);
        check("rst_addr",  bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_be",    {28'd0, bus.mem_be}, 32'd0);
        rst_n = 1'b1;
        tick();

        // SW full word, zero wait
        run_sw("sw100", 32'h0000_0100, 32'hDEAD_BEEF);
        tick();

        // SB into lane 3 and lane 0, SH into low half
        run_rmw("sb203", 3'b001, 32'h0000_0203, 32'h0000_00AB, 32'h1122_3344, 32'hAB22_3344, 4'b1000);
        tick();
        run_rmw("sb900", 3'b001, 32'h0000_0900, 32'hFFFF_FFCD, 32'hAABB_CCDD, 32'hAABB_CCCD, 4'b0001);
        tick();
        run_rmw("sha00", 3'b010, 32'h0000_0A00, 32'h1234_5678, 32'hAABB_CCDD, 32'hAABB_5678, 4'b0011);
        tick();

        // SH upper half with two wait cycles per phase: done at +7
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hFFFF_FFFF;
        drive_req(3'b010, 32'h0000_0302, 32'h0000_CAFE);
        tick();                                   // +1 RD wait
        idle_req();
        check("sh_rd1_req",  {31'd0, bus.mem_req}, 32'd1);
        check("sh_rd1_we",   {31'd0, bus.mem_we}, 32'd0);
        check("sh_rd1_addr", bus.mem_addr, 32'h0000_0300);
        check("sh_rd1_busy", {31'd0, bus.st_busy}, 32'd1);
        tick();                                   // +2 RD wait
        check("sh_rd2_we",   {31'd0, bus.mem_we}, 32'd0);
        check("sh_rd2_addr", bus.mem_addr, 32'h0000_0300);
        tick();                                   // +3 RD ack
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1122_3344;
        check("sh_rd3_we",   {31'd0, bus.mem_we}, 32'd0);
        tick();                                   // +4 WR wait
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hFFFF_FFFF;
        check("sh_wr4_we",   {31'd0, bus.mem_we}, 32'd1);
        check("sh_wr4_data", bus.mem_wdata, 32'hCAFE_3344);
        check("sh_wr4_be",   {28'd0, bus.mem_be}, 32'h0000_000C);
        check("sh_wr4_addr", bus.mem_addr, 32'h0000_0300);
        tick();                                   // +5 WR wait
        check("sh_wr5_req",  {31'd0, bus.mem_req}, 32'd1);
        check("sh_wr5_data", bus.mem_wdata, 32'hCAFE_3344);
        check("sh_wr5_be",   {28'd0, bus.mem_be}, 32'h0000_000C);
        check("sh_wr5_done", {31'd0, bus.st_done}, 32'd0);
        tick();                                   // +6 WR ack
        bus.mem_ack = 1'b1;
        check("sh_wr6_data", bus.mem_wdata, 32'hCAFE_3344);
        check("sh_wr6_busy", {31'd0, bus.st_busy}, 32'd1);
        tick();                                   // +7 DONE
        bus.mem_ack = 1'b0;
        check("sh_done7",    {31'd0, bus.st_done}, 32'd1);
        check("sh_busy7",    {31'd0, bus.st_busy}, 32'd1);
        check("sh_req7",     {31'd0, bus.mem_req}, 32'd0);
        tick();
        check("sh_idle8",    {31'd0, bus.st_busy}, 32'd0);
        tick();

        // Misaligned stores
        run_mis("mis_sh401", 3'b010, 32'h0000_0401);
        tick();
        run_mis("mis_sw402", 3'b011, 32'h0000_0402);
        tick();

        // Asynchronous reset during the read phase of an SB
        bus.mem_ack = 1'b0;
        drive_req(3'b001, 32'h0000_0501, 32'h0000_0077);
        tick();
        idle_req();
        check("rst_mid_rd_req", {31'd0, bus.mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_req",  {31'd0, bus.mem_req}, 32'd0);
        check("rst_mid_busy", {31'd0, bus.st_busy}, 32'd0);
        bus.mem_ack = 1'b1;
        tick();
        rst_n = 1'b1;
        bus.mem_ack = 1'b0;
        tick();
        check("rst_after_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_after_we",  {31'd0, bus.mem_we}, 32'd0);
        run_sw("sw600", 32'h0000_0600, 32'h1234_5678);
        tick();

        // Ignored requests: no-op and invalid opcodes
        bus.mem_ack = 1'b0;
        drive_req(3'b000, 32'h0000_0700, 32'h1111_1111);
        tick();
        check("op000_req",  {31'd0, bus.mem_req}, 32'd0);
        check("op000_busy", {31'd0, bus.st_busy}, 32'd0);
        drive_req(3'b111, 32'h0000_0700, 32'h1111_1111);
        tick();
        check("op111_req",  {31'd0, bus.mem_req}, 32'd0);
        check("op111_busy", {31'd0, bus.st_busy}, 32'd0);
        idle_req();
        tick();
        check("op111_done", {31'd0, bus.st_done}, 32'd0);

        // Request while busy is ignored
        drive_req(3'b011, 32'h0000_0704, 32'h0BAD_F00D);
        tick();                                   // WR waiting
        drive_req(3'b001, 32'h0000_0803, 32'h5555_5555);
        tick();
        check("busy_addr", bus.mem_addr, 32'h0000_0704);
        check("busy_we",   {31'd0, bus.mem_we}, 32'd1);
        check("busy_data", bus.mem_wdata, 32'h0BAD_F00D);
        check("busy_be",   {28'd0, bus.mem_be}, 32'h0000_000F);
        idle_req();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("busy_done", {31'd0, bus.st_done}, 32'd1);
        tick();
        check("busy_done0", {31'd0, bus.st_done}, 32'd0);
        check("busy_idle",  {31'd0, bus.st_busy}, 32'd0);
        tick();
        check("busy_noextra_done", {31'd0, bus.st_done}, 32'd0);
        check("busy_noextra_req",  {31'd0, bus.mem_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Store-side counterpart of the load alignment/extension path.
- Accepts SB/SH/SW requests from the MEM stage and produces full-word writes to a word-wide data memory with no native byte-write support.
- Sub-word stores use read-modify-write: read the word, merge the byte or halfword lane, write the word back.
- Stalls the pipeline through st_busy and flags misaligned stores instead of issuing them.

Parameters:
- ADDR_W, 32, byte-address width; memory address is word-aligned (addr[1:0] forced to 0).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- st_req  in  1  store request, sampled only in IDLE
- Storeop  in  3  000 none, 001 SB, 010 SH, 011 SW, others none
- addr  in  ADDR_W  byte address of the store
- datain  in  32  store data, right-justified (rt value)
- st_busy  out  1  high whenever state != IDLE
- st_done  out  1  one-cycle pulse on completion
- st_misalign  out  1  one-cycle pulse with st_done when the store was rejected
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  32  merged word
- mem_be  out  4  informational lane mask of the store, valid with write
- mem_rdata  in  32  read data, valid when mem_ack and mem_we = 0
- mem_ack  in  1  completes the current phase; may be asserted in the same cycle as mem_req

Behaviour:
- Reset (async, rst_n = 0): state IDLE; all outputs 0; captured registers cleared. Reset mid-transaction drops mem_req immediately. A write whose ack was not yet seen counts as not performed.
- Byte lanes are little-endian, consistent with the load path: lane k = bits [8k+7:8k].
- Acceptance: in IDLE with st_req = 1 and Storeop in {SB, SH, SW}, capture Storeop, addr and datain. Inputs may change afterwards. Requests with Storeop none/invalid are ignored: no done pulse. st_req while busy is ignored.
- Alignment check at acceptance:
  - SH with addr[0] = 1 is misaligned.
  - SW with addr[1:0] != 0 is misaligned.
  - A misaligned store goes to DONE with st_misalign = 1, and no memory access occurs.
- States:
  - IDLE: accept as above. Next state is RD (SB/SH), WR (SW), or DONE (misaligned).
  - RD: mem_req = 1, mem_we = 0. On mem_ack, latch mem_rdata as old_word and go to WR.
  - WR: mem_req = 1, mem_we = 1, mem_wdata = merged word. On mem_ack, go to DONE.
  - DONE: st_done = 1 (plus st_misalign if flagged) for exactly one cycle, then IDLE.
- Merge rules:
  - SB: lane addr[1:0] = datain[7:0]; other lanes from old_word; mem_be = 1 << addr[1:0].
  - SH: addr[1] = 0 gives [15:0] = datain[15:0], mem_be = 0011. addr[1] = 1 gives [31:16] = datain[15:0], mem_be = 1100. The other half comes from old_word.
  - SW: mem_wdata = datain, mem_be = 1111.
- mem_wdata, mem_be and mem_addr are registered or stable for the whole WR phase. They must not change while mem_req is high without ack.
- Latency from the acceptance cycle with zero-wait ack: SW done at +2; SB/SH done at +3; misaligned done at +1. Each wait cycle on mem_ack adds one cycle.
- A new request may be accepted in the cycle after DONE (IDLE). Back-to-back stores are therefore separated by at least one idle cycle.
- st_busy is asserted in RD, WR and DONE.

Decomposition:
- Shared package (mips_mem_pkg):
  - Storeop encodings (SOP_NONE, SOP_SB, SOP_SH, SOP_SW), numbered to parallel the Loadop codes.
  - FSM state enum {S_IDLE, S_RD, S_WR, S_DONE}.
  - Lane-mask constants.
- Sub-module store_lane_merge: combinational. Inputs op, addr[1:0], datain, old_word. Outputs merged word and byte enable. The FSM in store_merge_unit instantiates it once.

Test Plan:
- SW addr 0x100, datain 0xDEADBEEF, ack immediate -> one write: mem_addr 0x100, mem_wdata 0xDEADBEEF, mem_be 1111; st_done at acceptance +2; no read issued.
- SB addr 0x203, datain 0x000000AB, memory word 0x11223344, ack immediate -> read 0x200 then write 0xAB223344, mem_be 1000; st_done at +3.
- SH addr 0x302, datain 0x0000CAFE, memory 0x11223344, mem_ack delayed 2 cycles per phase -> write 0xCAFE3344, mem_be 1100; request fields stable during wait; st_done at +7; st_busy high throughout.
- SH addr 0x401 and SW addr 0x402 -> no mem_req; st_done and st_misalign both pulse at +1.
- rst_n driven low during RD of an SB -> mem_req and st_busy drop asynchronously; no write occurs; after release, a new SW completes normally.
- st_req with Storeop 000/111, and st_req while busy -> ignored: no mem_req, no extra st_done.
